// File: rtl/secded_pkg.sv
// Shared types, widths and the Hamming (15,11)+overall-parity encode function.
package secded_pkg;

  localparam int unsigned MSG_W = 11;
  localparam int unsigned CW_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } enc_state_t;

  // m[k] carries data bit d(k+1); parity bits sit at codeword positions 0,1,2,4,8.
  function automatic logic [CW_W-1:0] hamming_encode(input logic [MSG_W-1:0] m);
    logic p8, p4, p2, p1, p0;
    p8 = ^m[10:4];
    p4 = (^m[10:7]) ^ (^m[3:1]);
    p2 = m[10] ^ m[9] ^ m[6] ^ m[5] ^ m[3] ^ m[2] ^ m[0];
    p1 = m[10] ^ m[8] ^ m[6] ^ m[4] ^ m[3] ^ m[1] ^ m[0];
    p0 = (^m) ^ p8 ^ p4 ^ p2 ^ p1;
    return {m[10:4], p8, m[3:1], p4, m[0], p2, p1, p0};
  endfunction

endpackage

// File: rtl/secded_encode_engine_enc_comb.sv
// Purely combinational 11-bit message to 16-bit SECDED codeword encoder.
module secded_enc_comb
  import secded_pkg::*;
(
  input  logic [MSG_W-1:0] msg_i,
  output logic [CW_W-1:0]  cw_o
);

  // Encode is a pure function of the message bits.
  assign cw_o = hamming_encode(msg_i);

endmodule

// File: rtl/secded_encode_engine.sv
// Memory-mastering engine: reads raw messages, writes SECDED codewords, flags done.
module secded_encode_engine
  import secded_pkg::*;
#(
  parameter int unsigned NUM_MSG  = 15,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 30,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);

  localparam int unsigned IW = $clog2(NUM_MSG) + 1;

  enc_state_t      state_q;
  logic [IW-1:0]   idx_q;
  logic [7:0]      lo_q;
  logic [2:0]      hi_q;

  logic [CW_W-1:0] cw_c;
  logic [AW-1:0]   offs_c;
  logic [AW-1:0]   src_addr_c;
  logic [AW-1:0]   dst_addr_c;
  logic            unused_rd_hi_c;

  // Upper bits of the high source byte carry no message content.
  assign unused_rd_hi_c = ^mem_rd_data[7:3];

  // Codeword formed from the two capture registers.
  secded_enc_comb u_enc (
    .msg_i ({hi_q, lo_q}),
    .cw_o  (cw_c)
  );

  // Byte offset of message idx within a region, wrapping modulo 2^AW.
  assign offs_c     = AW'({idx_q, 1'b0});
  assign src_addr_c = AW'(SRC_BASE) + offs_c;
  assign dst_addr_c = AW'(DST_BASE) + offs_c;

  // Sequencer: four cycles per message, start honoured only in IDLE/DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RD_LO;
            idx_q   <= '0;
          end
        end
        RD_LO: begin
          lo_q    <= mem_rd_data;
          state_q <= RD_HI;
        end
        RD_HI: begin
          hi_q    <= mem_rd_data[2:0];
          state_q <= WR_LO;
        end
        WR_LO: begin
          state_q <= WR_HI;
        end
        WR_HI: begin
          if (idx_q == IW'(NUM_MSG - 1)) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + IW'(1);
            state_q <= RD_LO;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory port decoded directly from state so reset silences writes at once.
  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    done        = 1'b0;
    case (state_q)
      RD_LO: mem_addr = src_addr_c;
      RD_HI: mem_addr = src_addr_c + AW'(1);
      WR_LO: begin
        mem_addr    = dst_addr_c;
        mem_wr_en   = 1'b1;
        mem_wr_data = cw_c[7:0];
      end
      WR_HI: begin
        mem_addr    = dst_addr_c + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = cw_c[15:8];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_secded_encode_engine.sv
// Bench for secded_encode_engine: byte memory model plus write scoreboard.
module tb_secded_encode_engine;

  localparam int NUM_MSG = 15;
  localparam int SRC     = 0;
  localparam int DST     = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];

  int errors = 0;
  int checks = 0;

  logic [10:0] u_msg;
  logic [15:0] u_cw;

  secded_encode_engine #(
    .NUM_MSG  (NUM_MSG),
    .SRC_BASE (SRC),
    .DST_BASE (DST),
    .AW       (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  secded_enc_comb u_enc (
    .msg_i (u_msg),
    .cw_o  (u_cw)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];

  // Memory commits and records every write at the rising edge.
  always @(posedge clk) begin
    if (mem_wr_en === 1'b1) begin
      mem[mem_addr] = mem_wr_data;
      obs_q.push_back({mem_addr, mem_wr_data});
    end
  end

  // Reference encoder built from Hamming position indices, not from the spec equations.
  function automatic logic [15:0] model_cw(input logic [10:0] m);
    logic [15:0] cw;
    logic [3:0]  syn;
    int          k;
    cw  = '0;
    syn = '0;
    k   = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
        cw[pos] = m[k];
        if (m[k]) syn = syn ^ 4'(pos);
        k++;
      end
    end
    cw[1] = syn[0];
    cw[2] = syn[1];
    cw[4] = syn[2];
    cw[8] = syn[3];
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [3:0] syndrome(input logic [15:0] cw);
    logic [3:0] s;
    s = '0;
    for (int pos = 1; pos < 16; pos++) if (cw[pos]) s = s ^ 4'(pos);
    return s;
  endfunction

  task automatic load_random();
    for (int i = 0; i < 2 * NUM_MSG; i++) mem[SRC + i] = 8'($urandom);
  endtask

  task automatic fill_dst(input logic [7:0] v);
    for (int i = 0; i < 2 * NUM_MSG; i++) mem[DST + i] = v;
  endtask

  // Queue the expected write stream for the current source image.
  task automatic push_expected();
    logic [10:0] d;
    logic [15:0] cw;
    exp_q.delete();
    for (int i = 0; i < NUM_MSG; i++) begin
      d  = {mem[SRC + 2 * i + 1][2:0], mem[SRC + 2 * i]};
      cw = model_cw(d);
      exp_q.push_back({8'(DST + 2 * i), cw[7:0]});
      exp_q.push_back({8'(DST + 2 * i + 1), cw[15:8]});
    end
  endtask

  // Start a run, optionally pulse start again at edge pulse_at, and reconcile writes.
  task automatic do_run(input int pulse_at, output int done_at, output logic done_after,
                        output int nwr, output int nbad);
    logic [15:0] e, o;
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    done_after = done;
    done_at    = -1;
    for (int k = 1; k <= 70 && done_at < 0; k++) begin
      start = (k == pulse_at);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done === 1'b1) done_at = k;
    end
    nwr  = obs_q.size();
    nbad = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        nbad++;
        $display("  missing write addr=%02h data=%02h", e[15:8], e[7:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          nbad++;
          $display("  write got addr=%02h data=%02h exp addr=%02h data=%02h",
                   o[15:8], o[7:0], e[15:8], e[7:0]);
        end
      end
    end
    nbad += obs_q.size();
    obs_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", mem_wr_en); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%02h exp=00", mem_addr); end
    checks++; if (mem_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got=%02h exp=00", mem_wr_data); end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_addr !== 8'h00 || mem_wr_en !== 1'b0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_start_ignored got addr=%02h wr_en=%b writes=%0d exp 00/0/0",
               mem_addr, mem_wr_en, obs_q.size());
    end
  endtask

  task automatic test_directed();
    int done_at, nwr, nbad;
    logic da;
    load_random();
    mem[SRC + 0] = 8'h00; mem[SRC + 1] = 8'hF8;
    mem[SRC + 2] = 8'hFF; mem[SRC + 3] = 8'hFF;
    mem[SRC + 4] = 8'h01; mem[SRC + 5] = 8'h00;
    fill_dst(8'hA5);
    push_expected();
    do_run(-1, done_at, da, nwr, nbad);
    checks++; if (done_at !== 60) begin errors++; $display("FAIL dir_done_cycle got=%0d exp=60", done_at); end
    checks++; if (nwr !== 30) begin errors++; $display("FAIL dir_write_count got=%0d exp=30", nwr); end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL dir_scoreboard got=%0d bad exp=0", nbad); end
    checks++; if ({mem[DST + 1], mem[DST + 0]} !== 16'h0000) begin errors++; $display("FAIL dir_cw_000 got=%04h exp=0000", {mem[DST + 1], mem[DST + 0]}); end
    checks++; if ({mem[DST + 3], mem[DST + 2]} !== 16'hFFFF) begin errors++; $display("FAIL dir_cw_7ff got=%04h exp=ffff", {mem[DST + 3], mem[DST + 2]}); end
    checks++; if ({mem[DST + 5], mem[DST + 4]} !== 16'h000F) begin errors++; $display("FAIL dir_cw_001 got=%04h exp=000f", {mem[DST + 5], mem[DST + 4]}); end
  endtask

  task automatic test_start_in_done();
    int done_at, nwr, nbad, ndiff;
    logic da;
    logic [7:0] snap [30];
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rerun_pre_done got=%b exp=1", done); end
    for (int i = 0; i < 30; i++) snap[i] = mem[DST + i];
    fill_dst(8'h5A);
    push_expected();
    do_run(-1, done_at, da, nwr, nbad);
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL rerun_done_drop got=%b exp=0", da); end
    checks++; if (done_at !== 60) begin errors++; $display("FAIL rerun_done_cycle got=%0d exp=60", done_at); end
    checks++; if (nbad !== 0 || nwr !== 30) begin errors++; $display("FAIL rerun_scoreboard got bad=%0d writes=%0d exp 0/30", nbad, nwr); end
    ndiff = 0;
    for (int i = 0; i < 30; i++) if (mem[DST + i] !== snap[i]) ndiff++;
    checks++; if (ndiff !== 0) begin errors++; $display("FAIL rerun_identical got=%0d differing bytes exp=0", ndiff); end
  endtask

  task automatic test_start_ignored();
    int done_at, nwr, nbad;
    logic da;
    load_random();
    fill_dst(8'h00);
    push_expected();
    do_run(20, done_at, da, nwr, nbad);
    checks++; if (done_at !== 60) begin errors++; $display("FAIL ign_done_cycle got=%0d exp=60", done_at); end
    checks++; if (nwr !== 30) begin errors++; $display("FAIL ign_write_count got=%0d exp=30", nwr); end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL ign_scoreboard got=%0d bad exp=0", nbad); end
  endtask

  task automatic test_reset_midrun();
    int done_at, nwr, nbad;
    logic da;
    logic [15:0] e, o;
    load_random();
    fill_dst(8'h00);
    push_expected();
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (26) @(posedge clk);
    #1;
    checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL mid_pre_wr_en got=%b exp=1", mem_wr_en); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL mid_wr_en_async got=%b exp=0", mem_wr_en); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=0", done); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== 12) begin errors++; $display("FAIL mid_write_count got=%0d exp=12", obs_q.size()); end
    nbad = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) nbad++;
    end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL mid_partial_data got=%0d bad exp=0", nbad); end
    checks++; if (done !== 1'b0 || mem_wr_en !== 1'b0) begin errors++; $display("FAIL mid_idle got done=%b wr_en=%b exp 0/0", done, mem_wr_en); end
    exp_q.delete();
    obs_q.delete();
    load_random();
    fill_dst(8'hC3);
    push_expected();
    do_run(-1, done_at, da, nwr, nbad);
    checks++; if (done_at !== 60) begin errors++; $display("FAIL fresh_done_cycle got=%0d exp=60", done_at); end
    checks++; if (nbad !== 0 || nwr !== 30) begin errors++; $display("FAIL fresh_scoreboard got bad=%0d writes=%0d exp 0/30", nbad, nwr); end
  endtask

  task automatic test_enc_comb_exhaustive();
    logic [15:0] cw, exp_cw;
    for (int v = 0; v < 2048; v++) begin
      u_msg = 11'(v);
      #1;
      cw     = u_cw;
      exp_cw = model_cw(11'(v));
      checks++;
      if (cw !== exp_cw || syndrome(cw) !== 4'h0 || (^cw) !== 1'b0) begin
        errors++;
        $display("FAIL enc_comb msg=%03h got=%04h exp=%04h syn=%h par=%b",
                 v, cw, exp_cw, syndrome(cw), ^cw);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    u_msg = '0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    test_reset();
    test_directed();
    test_start_in_done();
    test_start_ignored();
    test_reset_midrun();
    test_enc_comb_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
